rm_step_scheduler: RTL and testbench

//  Sequences retirements from the DUT RVFI into single, in-order ISS step requests for the reference model.
//  Per cycle, up to NRET lanes retire into an internal FIFO; one step is issued at a time over a req/ack handshake.
//  The ISS answers each step with its next PC; the block compares it against the DUT's next retired PC.

---
 rtl/rm_step_scheduler.sv | 244 ++++++++++++++++++++++++
 tb/tb_rm_step_scheduler.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rm_step_scheduler.sv
// ---------------------------------------------------------------------------
// rm_step_scheduler
//   Turns RVFI retirements (up to NRET lanes per cycle) into single, in-order
//   step requests for the instruction-set simulator. Retired lanes are
//   buffered in a small FIFO. One step is issued at a time over a req/ack
//   handshake. The PC the ISS reports after each step is compared against
//   the PC of the next instruction the DUT retired.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   rvfi_valid_i        per-lane retirement valid
//   rvfi_order_i        per-lane instruction order (64 bits per lane)
//   rvfi_pc_rdata_i     per-lane PC (XLEN bits per lane)
//   rvfi_intr_i         per-lane "first instruction of a trap handler"
//   irq_i               interrupt lines, captured with every stored entry
//   step_req_o          step request to the ISS
//   step_pc_o/_order_o  PC and order of the step in flight
//   step_irq_o/_intr_o  irq snapshot and trap-entry flag of that step
//   step_ack_i          ISS finished the step; step_next_pc_i is valid
//   step_next_pc_i      ISS PC after the step
//   mismatch_o          sticky PC/order mismatch
//   overflow_o          sticky FIFO overflow (a whole cycle's lanes dropped)
//   retired_cnt_o       number of completed steps (wraps modulo 2^64)
//   busy_o              FIFO non-empty, or a step is in progress
// ---------------------------------------------------------------------------
module rm_step_scheduler #(
  parameter int unsigned NRET             = 2,
  parameter int unsigned XLEN             = 32,
  parameter int unsigned DEPTH            = 8,
  parameter bit          STOP_ON_MISMATCH = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NRET-1:0]      rvfi_valid_i,
  input  logic [NRET*64-1:0]   rvfi_order_i,
  input  logic [NRET*XLEN-1:0] rvfi_pc_rdata_i,
  input  logic [NRET-1:0]      rvfi_intr_i,
  input  logic [31:0]          irq_i,
  output logic                 step_req_o,
  output logic [XLEN-1:0]      step_pc_o,
  output logic [63:0]          step_order_o,
  output logic [31:0]          step_irq_o,
  output logic                 step_intr_o,
  input  logic                 step_ack_i,
  input  logic [XLEN-1:0]      step_next_pc_i,
  output logic                 mismatch_o,
  output logic                 overflow_o,
  output logic [63:0]          retired_cnt_o,
  output logic                 busy_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [63:0]     order;
    logic            intr;
    logic [31:0]     irq;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CHECK = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  entry_t        step_q, step_d;
  logic [XLEN-1:0] next_pc_q, next_pc_d;
  logic [63:0]   exp_order_q, exp_order_d;
  logic [63:0]   retired_cnt_q, retired_cnt_d;
  logic          mismatch_q, mismatch_d;
  logic          overflow_q, overflow_d;

  entry_t        mem [DEPTH];
  entry_t        lane_entry [NRET];
  logic [AW-1:0] lane_off  [NRET];
  logic [AW-1:0] lane_addr [NRET];
  logic          slot_we    [DEPTH];
  entry_t        slot_wdata [DEPTH];

  logic [AW:0]   count;
  logic [AW:0]   free_slots;
  logic [AW:0]   push_cnt;
  logic          push_ok;
  logic          fifo_empty;
  logic          head_avail;
  entry_t        byp_entry;
  entry_t        head;
  logic          pop;
  logic          pc_mis;
  logic          ord_mis;

  // Unpack lanes into entries and compute each lane's slot address.
  for (genvar gi = 0; gi < NRET; gi++) begin : g_lane
    assign lane_entry[gi] = '{pc:    rvfi_pc_rdata_i[gi*XLEN +: XLEN],
                              order: rvfi_order_i[gi*64 +: 64],
                              intr:  rvfi_intr_i[gi],
                              irq:   irq_i};
    assign lane_addr[gi]  = wr_ptr_q[AW-1:0] + lane_off[gi];
  end

  assign count      = wr_ptr_q - rd_ptr_q;
  assign free_slots = (AW+1)'(DEPTH) - count;
  assign fifo_empty = (count == '0);

  // Prefix count of valid lanes: valid lanes pack densely in lane order.
  always_comb begin
    push_cnt = '0;
    for (int k = 0; k < NRET; k++) begin
      lane_off[k] = push_cnt[AW-1:0];
      push_cnt    = push_cnt + {{AW{1'b0}}, rvfi_valid_i[k]};
    end
  end

  // All-or-nothing push, judged on occupancy before any same-cycle pop.
  assign push_ok = (push_cnt != '0) && (push_cnt <= free_slots);

  // The lowest valid lane is the one that lands at the head when the FIFO
  // is empty, so it can be consumed in the same cycle it arrives.
  always_comb begin
    byp_entry = lane_entry[0];
    for (int k = NRET - 1; k >= 0; k--) begin
      if (rvfi_valid_i[k]) byp_entry = lane_entry[k];
    end
  end

  assign head_avail = !fifo_empty || push_ok;
  assign head       = fifo_empty ? byp_entry : mem[rd_ptr_q[AW-1:0]];

  always_comb begin
    for (int s = 0; s < DEPTH; s++) begin
      slot_we[s]    = 1'b0;
      slot_wdata[s] = '0;
    end
    for (int k = 0; k < NRET; k++) begin
      if (push_ok && rvfi_valid_i[k]) begin
        slot_we[lane_addr[k]]    = 1'b1;
        slot_wdata[lane_addr[k]] = lane_entry[k];
      end
    end
  end

  // Storage carries no reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    for (int s = 0; s < DEPTH; s++) begin
      if (slot_we[s]) mem[s] <= slot_wdata[s];
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d       = state_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = push_ok ? (wr_ptr_q + push_cnt) : wr_ptr_q;
    step_d        = step_q;
    next_pc_d     = next_pc_q;
    exp_order_d   = exp_order_q;
    retired_cnt_d = retired_cnt_q;
    mismatch_d    = mismatch_q;
    overflow_d    = overflow_q | (push_cnt > free_slots);
    pop           = 1'b0;
    pc_mis        = !head.intr && (head.pc != next_pc_q);
    ord_mis       = (head.order != exp_order_q);

    unique case (state_q)
      IDLE: begin
        if (head_avail) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (step_ack_i) begin
          next_pc_d     = step_next_pc_i;
          retired_cnt_d = retired_cnt_q + 64'd1;
          state_d       = CHECK;
        end
      end
      CHECK: begin
        if (head_avail) begin
          if (STOP_ON_MISMATCH && (pc_mis || ord_mis)) begin
            // Leave the offending entry in the FIFO for post-mortem.
            mismatch_d = 1'b1;
            state_d    = HALT;
          end else begin
            if (pc_mis) mismatch_d = 1'b1;
            pop     = 1'b1;
            state_d = ISSUE;
          end
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      if (ord_mis) mismatch_d = 1'b1;
      exp_order_d = head.order + 64'd1;
      step_d      = head;
      rd_ptr_d    = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      step_q        <= '0;
      next_pc_q     <= '0;
      exp_order_q   <= 64'd1;
      retired_cnt_q <= '0;
      mismatch_q    <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      step_q        <= step_d;
      next_pc_q     <= next_pc_d;
      exp_order_q   <= exp_order_d;
      retired_cnt_q <= retired_cnt_d;
      mismatch_q    <= mismatch_d;
      overflow_q    <= overflow_d;
    end
  end

  assign step_req_o    = (state_q == ISSUE);
  assign step_pc_o     = step_q.pc;
  assign step_order_o  = step_q.order;
  assign step_irq_o    = step_q.irq;
  assign step_intr_o   = step_q.intr;
  assign mismatch_o    = mismatch_q;
  assign overflow_o    = overflow_q;
  assign retired_cnt_o = retired_cnt_q;
  assign busy_o        = ((state_q != IDLE) && (state_q != HALT)) || !fifo_empty;

endmodule

// File: tb/tb_rm_step_scheduler.sv
module tb_rm_step_scheduler;

  logic          clk;
  logic          reset_n;
  logic [1:0]    rvfi_valid;
  logic [127:0]  rvfi_order;
  logic [63:0]   rvfi_pc;
  logic [1:0]    rvfi_intr;
  logic [31:0]   irq;
  logic          step_req;
  logic [31:0]   step_pc;
  logic [63:0]   step_order;
  logic [31:0]   step_irq;
  logic          step_intr;
  logic          step_ack;
  logic [31:0]   step_next_pc;
  logic          mismatch;
  logic          overflow;
  logic [63:0]   retired_cnt;
  logic          busy;

  int tests;
  int fails;

  rm_step_scheduler #(
    .NRET(2), .XLEN(32), .DEPTH(8), .STOP_ON_MISMATCH(1'b1)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .rvfi_valid_i    (rvfi_valid),
    .rvfi_order_i    (rvfi_order),
    .rvfi_pc_rdata_i (rvfi_pc),
    .rvfi_intr_i     (rvfi_intr),
    .irq_i           (irq),
    .step_req_o      (step_req),
    .step_pc_o       (step_pc),
    .step_order_o    (step_order),
    .step_irq_o      (step_irq),
    .step_intr_o     (step_intr),
    .step_ack_i      (step_ack),
    .step_next_pc_i  (step_next_pc),
    .mismatch_o      (mismatch),
    .overflow_o      (overflow),
    .retired_cnt_o   (retired_cnt),
    .busy_o          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    logic [1:0]  valid;
    logic [1:0]  intr;
    logic [63:0] ord0;
    logic [63:0] ord1;
    logic [31:0] pc0;
    logic [31:0] pc1;
    logic [31:0] irq;
    logic        ack;
    logic [31:0] npc;
    logic        e_req;
    logic [31:0] e_pc;
    logic [63:0] e_ord;
    logic [31:0] e_irq;
    logic        e_intr;
    logic [63:0] e_cnt;
    logic        e_mis;
    logic        e_ovf;
  } vec_t;

  vec_t vecs [25];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] in, input logic [63:0] o0,
                       input logic [63:0] o1, input logic [31:0] p0, input logic [31:0] p1,
                       input logic [31:0] iq, input logic ack, input logic [31:0] npc);
    rvfi_valid   = v;
    rvfi_intr    = in;
    rvfi_order   = {o1, o0};
    rvfi_pc      = {p1, p0};
    irq          = iq;
    step_ack     = ack;
    step_next_pc = npc;
  endtask

  task automatic idle_inputs();
    drive(2'b00, 2'b00, 64'd0, 64'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // Completes the step in flight with a correct next PC, then lets the
  // CHECK cycle run.
  task automatic expect_step(input string tag, input logic [63:0] ord, input logic [31:0] pc);
    chk({tag, " req"}, {63'd0, step_req}, 64'd1);
    chk({tag, " order"}, step_order, ord);
    chk({tag, " pc"}, {32'd0, step_pc}, {32'd0, pc});
    step_ack     = 1'b1;
    step_next_pc = pc + 32'd4;
    tick();
    step_ack = 1'b0;
    chk({tag, " req after ack"}, {63'd0, step_req}, 64'd0);
    tick();
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    reset_n = 1'b1;
    idle_inputs();

    // rst valid intr ord0 ord1 pc0 pc1 irq ack npc | req pc ord irq intr cnt mis ovf
    // Single lane, orders 1..4, same-cycle acks.
    vecs[0]  = '{1, 2'b01, 2'b00, 1, 0, 'h80, 0, 0, 0, 0,      1, 'h80, 1, 0, 0, 0, 0, 0};
    vecs[1]  = '{0, 2'b01, 2'b00, 2, 0, 'h84, 0, 0, 1, 'h84,   0, 'h80, 1, 0, 0, 1, 0, 0};
    vecs[2]  = '{0, 2'b01, 2'b00, 3, 0, 'h88, 0, 0, 0, 0,      1, 'h84, 2, 0, 0, 1, 0, 0};
    vecs[3]  = '{0, 2'b01, 2'b00, 4, 0, 'h8C, 0, 0, 1, 'h88,   0, 'h84, 2, 0, 0, 2, 0, 0};
    vecs[4]  = '{0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0,         1, 'h88, 3, 0, 0, 2, 0, 0};
    vecs[5]  = '{0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 'h8C,      0, 'h88, 3, 0, 0, 3, 0, 0};
    vecs[6]  = '{0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0,         1, 'h8C, 4, 0, 0, 3, 0, 0};
    vecs[7]  = '{0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 'h90,      0, 'h8C, 4, 0, 0, 4, 0, 0};
    // Two lanes in one cycle; irq captured at ingest.
    vecs[8]  = '{1, 2'b11, 2'b00, 1, 2, 'h100, 'h104, 'h11, 0, 0, 1, 'h100, 1, 'h11, 0, 0, 0, 0};
    vecs[9]  = '{0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 'h104,     0, 'h100, 1, 'h11, 0, 1, 0, 0};
    vecs[10] = '{0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0,         1, 'h104, 2, 'h11, 0, 1, 0, 0};
    vecs[11] = '{0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 'h108,     0, 'h104, 2, 'h11, 0, 2, 0, 0};
    // Wrong ISS next PC (intr=0): mismatch and halt; stray ack ignored.
    vecs[12] = '{1, 2'b01, 2'b00, 1, 0, 'h80, 0, 0, 0, 0,      1, 'h80, 1, 0, 0, 0, 0, 0};
    vecs[13] = '{0, 2'b01, 2'b00, 2, 0, 'h88, 0, 0, 1, 'h90,   0, 'h80, 1, 0, 0, 1, 0, 0};
    vecs[14] = '{0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0,         0, 'h80, 1, 0, 0, 1, 1, 0};
    vecs[15] = '{0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 0,         0, 'h80, 1, 0, 0, 1, 1, 0};
    // Same PCs but next entry is a trap entry: compare skipped.
    vecs[16] = '{1, 2'b01, 2'b00, 1, 0, 'h80, 0, 0, 0, 0,      1, 'h80, 1, 0, 0, 0, 0, 0};
    vecs[17] = '{0, 2'b01, 2'b01, 2, 0, 'h88, 0, 0, 1, 'h90,   0, 'h80, 1, 0, 0, 1, 0, 0};
    vecs[18] = '{0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0,         1, 'h88, 2, 0, 1, 1, 0, 0};
    vecs[19] = '{0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 'h8C,      0, 'h88, 2, 0, 1, 2, 0, 0};
    // First order after reset is not 1: order mismatch flagged at pop.
    vecs[20] = '{1, 2'b01, 2'b00, 5, 0, 'h40, 0, 0, 0, 0,      1, 'h40, 5, 0, 0, 0, 1, 0};
    // Lane 1 alone: only lane 1's data is pushed.
    vecs[21] = '{1, 2'b10, 2'b00, 7, 1, 'h70, 'hA0, 0, 0, 0,   1, 'hA0, 1, 0, 0, 0, 0, 0};
    vecs[22] = '{0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 'hA4,      0, 'hA0, 1, 0, 0, 1, 0, 0};
    vecs[23] = '{0, 2'b01, 2'b00, 2, 0, 'hA4, 0, 0, 0, 0,      1, 'hA4, 2, 0, 0, 1, 0, 0};
    vecs[24] = '{0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 'hA8,      0, 'hA4, 2, 0, 0, 2, 0, 0};

    // Reset state.
    do_reset();
    chk("rst req", {63'd0, step_req}, 64'd0);
    chk("rst pc", {32'd0, step_pc}, 64'd0);
    chk("rst order", step_order, 64'd0);
    chk("rst irq", {32'd0, step_irq}, 64'd0);
    chk("rst intr", {63'd0, step_intr}, 64'd0);
    chk("rst mismatch", {63'd0, mismatch}, 64'd0);
    chk("rst overflow", {63'd0, overflow}, 64'd0);
    chk("rst cnt", retired_cnt, 64'd0);
    chk("rst busy", {63'd0, busy}, 64'd0);

    for (int i = 0; i < 25; i++) begin
      if (vecs[i].rst) do_reset();
      drive(vecs[i].valid, vecs[i].intr, vecs[i].ord0, vecs[i].ord1, vecs[i].pc0,
            vecs[i].pc1, vecs[i].irq, vecs[i].ack, vecs[i].npc);
      tick();
      chk($sformatf("v%0d req", i), {63'd0, step_req}, {63'd0, vecs[i].e_req});
      chk($sformatf("v%0d pc", i), {32'd0, step_pc}, {32'd0, vecs[i].e_pc});
      chk($sformatf("v%0d order", i), step_order, vecs[i].e_ord);
      chk($sformatf("v%0d irq", i), {32'd0, step_irq}, {32'd0, vecs[i].e_irq});
      chk($sformatf("v%0d intr", i), {63'd0, step_intr}, {63'd0, vecs[i].e_intr});
      chk($sformatf("v%0d cnt", i), retired_cnt, vecs[i].e_cnt);
      chk($sformatf("v%0d mismatch", i), {63'd0, mismatch}, {63'd0, vecs[i].e_mis});
      chk($sformatf("v%0d overflow", i), {63'd0, overflow}, {63'd0, vecs[i].e_ovf});
      $display("[TB] vector %0d applied: req=%0d pc=%0h order=%0d cnt=%0d", i, step_req,
               step_pc, step_order, retired_cnt);
    end
    idle_inputs();

    // Delayed ack: request and payload hold for 5 cycles, no second request.
    do_reset();
    drive(2'b01, 2'b00, 64'd1, 64'd0, 32'h200, 32'd0, 32'd0, 1'b0, 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i == 0) drive(2'b01, 2'b00, 64'd2, 64'd0, 32'h204, 32'd0, 32'd0, 1'b0, 32'd0);
      else idle_inputs();
      tick();
      chk($sformatf("hold%0d req", i), {63'd0, step_req}, 64'd1);
      chk($sformatf("hold%0d pc", i), {32'd0, step_pc}, 64'h200);
      chk($sformatf("hold%0d order", i), step_order, 64'd1);
      chk($sformatf("hold%0d cnt", i), retired_cnt, 64'd0);
    end
    expect_step("hold s1", 64'd1, 32'h200);
    expect_step("hold s2", 64'd2, 32'h204);
    chk("hold cnt", retired_cnt, 64'd2);
    chk("hold mismatch", {63'd0, mismatch}, 64'd0);
    $display("[TB] delayed-ack sequence done: cnt=%0d", retired_cnt);

    // Overflow: FIFO at DEPTH-1, two lanes offered, both dropped.
    do_reset();
    drive(2'b01, 2'b00, 64'd1, 64'd0, 32'h300, 32'd0, 32'd0, 1'b0, 32'd0);
    tick();
    drive(2'b11, 2'b00, 64'd2, 64'd3, 32'h304, 32'h308, 32'd0, 1'b0, 32'd0);
    tick();
    drive(2'b11, 2'b00, 64'd4, 64'd5, 32'h30C, 32'h310, 32'd0, 1'b0, 32'd0);
    tick();
    drive(2'b11, 2'b00, 64'd6, 64'd7, 32'h314, 32'h318, 32'd0, 1'b0, 32'd0);
    tick();
    drive(2'b01, 2'b00, 64'd8, 64'd0, 32'h31C, 32'd0, 32'd0, 1'b0, 32'd0);
    tick();
    chk("ovf at depth-1", {63'd0, overflow}, 64'd0);
    drive(2'b11, 2'b00, 64'd9, 64'd10, 32'h320, 32'h324, 32'd0, 1'b0, 32'd0);
    tick();
    idle_inputs();
    chk("ovf set", {63'd0, overflow}, 64'd1);
    for (int k = 1; k <= 8; k++) begin
      expect_step($sformatf("drain%0d", k), 64'(k), 32'h300 + 32'(4 * (k - 1)));
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("drained%0d req", i), {63'd0, step_req}, 64'd0);
      chk($sformatf("drained%0d busy", i), {63'd0, busy}, 64'd1);
      tick();
    end
    chk("ovf sticky", {63'd0, overflow}, 64'd1);
    chk("ovf cnt", retired_cnt, 64'd8);
    chk("ovf mismatch", {63'd0, mismatch}, 64'd0);
    $display("[TB] overflow sequence done: cnt=%0d overflow=%0d", retired_cnt, overflow);

    // Reset mid-step: outputs clear at once; stale ack ignored; order restarts.
    do_reset();
    drive(2'b01, 2'b00, 64'd1, 64'd0, 32'h400, 32'd0, 32'd0, 1'b0, 32'd0);
    tick();
    drive(2'b01, 2'b00, 64'd2, 64'd0, 32'h404, 32'd0, 32'd0, 1'b0, 32'd0);
    tick();
    idle_inputs();
    expect_step("mid s1", 64'd1, 32'h400);
    chk("mid req before rst", {63'd0, step_req}, 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid rst req", {63'd0, step_req}, 64'd0);
    chk("mid rst pc", {32'd0, step_pc}, 64'd0);
    chk("mid rst order", step_order, 64'd0);
    chk("mid rst cnt", retired_cnt, 64'd0);
    chk("mid rst busy", {63'd0, busy}, 64'd0);
    step_ack     = 1'b1;
    step_next_pc = 32'h999;
    tick();
    reset_n = 1'b1;
    tick();
    chk("stale ack req", {63'd0, step_req}, 64'd0);
    chk("stale ack cnt", retired_cnt, 64'd0);
    chk("stale ack busy", {63'd0, busy}, 64'd0);
    drive(2'b01, 2'b00, 64'd1, 64'd0, 32'h500, 32'd0, 32'd0, 1'b0, 32'd0);
    tick();
    idle_inputs();
    chk("restart mismatch", {63'd0, mismatch}, 64'd0);
    expect_step("restart s1", 64'd1, 32'h500);
    chk("restart cnt", retired_cnt, 64'd1);
    $display("[TB] reset-mid-step sequence done: cnt=%0d mismatch=%0d", retired_cnt, mismatch);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
